// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - L1 data cache shared types, width derivation and address field helpers
package l1_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_FILL   = 3'd2,
        ST_WTHRU  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int calc_off_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int calc_idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int calc_tag_w(input int addr_width, input int off_w, input int idx_w);
        return addr_width - off_w - idx_w;
    endfunction

    // Generic bit-field extraction; callers cast the result down to the field width.
    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [63:0] get_idx(input logic [63:0] addr, input int off_w, input int idx_w);
        return addr_field(addr, off_w, idx_w);
    endfunction

    function automatic logic [63:0] get_tag(input logic [63:0] addr, input int off_w, input int idx_w,
                                            input int tag_w);
        return addr_field(addr, off_w + idx_w, tag_w);
    endfunction

endpackage

// File: rtl/l1_dcache_line_array.sv
// rtl/l1_dcache_line_array.sv - valid/tag/data line storage, async read, sync write
module l1_line_array #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 16,
    parameter int IDX_W      = 4,
    parameter int TAG_W      = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [NUM_LINES-1:0]  valid;
    logic [TAG_W-1:0]      tags  [NUM_LINES];
    logic [DATA_WIDTH-1:0] datas [NUM_LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = datas[rd_idx];

    // Valid bits are the only state that must be cleared; stale tag/data are masked by valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data write port.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx]  <= wr_tag;
            datas[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/l1_dcache.sv
// rtl/l1_dcache.sv - direct-mapped write-through L1 D-cache top; L1_PERF_CNT_EN adds hit/miss counters
module l1_dcache
    import l1_cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_LINES  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_hit,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    output logic [DATA_WIDTH-1:0] l2_wdata,
    output logic                  l2_read,
    output logic                  l2_write,
    input  logic [DATA_WIDTH-1:0] l2_rdata,
    input  logic                  l2_ready
`ifdef L1_PERF_CNT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam int OFF_W = calc_off_w(DATA_WIDTH);
    localparam int IDX_W = calc_idx_w(NUM_LINES);
    localparam int TAG_W = calc_tag_w(ADDR_WIDTH, OFF_W, IDX_W);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] req_addr, req_addr_n;
    logic [DATA_WIDTH-1:0] req_wdata, req_wdata_n;
    logic                  req_store, req_store_n;
    logic                  req_hit, req_hit_n;
    logic [DATA_WIDTH-1:0] cpu_rdata_n;
    logic                  cpu_ready_n, cpu_hit_n;
    logic [ADDR_WIDTH-1:0] l2_addr_n;
    logic [DATA_WIDTH-1:0] l2_wdata_n;
    logic                  l2_read_n, l2_write_n;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_WIDTH-1:0] line_data;
    logic                  lookup_hit;
    logic                  arr_we;
    logic [DATA_WIDTH-1:0] arr_wdata;

    assign req_idx    = IDX_W'(get_idx(64'(req_addr), OFF_W, IDX_W));
    assign req_tag    = TAG_W'(get_tag(64'(req_addr), OFF_W, IDX_W, TAG_W));
    assign lookup_hit = line_valid && (line_tag == req_tag);

    l1_line_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LINES  (NUM_LINES),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .we       (arr_we),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_data  (arr_wdata)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n     = state;
        req_addr_n  = req_addr;
        req_wdata_n = req_wdata;
        req_store_n = req_store;
        req_hit_n   = req_hit;
        cpu_rdata_n = cpu_rdata;
        cpu_ready_n = 1'b0;
        cpu_hit_n   = cpu_hit;
        l2_addr_n   = l2_addr;
        l2_wdata_n  = l2_wdata;
        l2_read_n   = l2_read;
        l2_write_n  = l2_write;
        arr_we      = 1'b0;
        arr_wdata   = req_wdata;
        case (state)
            ST_IDLE: begin
                if (cpu_write || cpu_read) begin
                    req_addr_n  = cpu_addr;
                    req_wdata_n = cpu_wdata;
                    req_store_n = cpu_write;
                    state_n     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                req_hit_n = lookup_hit;
                if (req_store) begin
                    // Update in place on a hit only; a store miss never allocates.
                    arr_we     = lookup_hit;
                    arr_wdata  = req_wdata;
                    l2_addr_n  = req_addr;
                    l2_wdata_n = req_wdata;
                    l2_write_n = 1'b1;
                    state_n    = ST_WTHRU;
                end else if (lookup_hit) begin
                    cpu_rdata_n = line_data;
                    cpu_hit_n   = 1'b1;
                    cpu_ready_n = 1'b1;
                    state_n     = ST_DONE;
                end else begin
                    l2_addr_n = req_addr;
                    l2_read_n = 1'b1;
                    state_n   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (l2_ready) begin
                    arr_we      = 1'b1;
                    arr_wdata   = l2_rdata;
                    cpu_rdata_n = l2_rdata;
                    cpu_hit_n   = 1'b0;
                    cpu_ready_n = 1'b1;
                    l2_read_n   = 1'b0;
                    state_n     = ST_DONE;
                end
            end
            ST_WTHRU: begin
                if (l2_ready) begin
                    cpu_hit_n   = req_hit;
                    cpu_ready_n = 1'b1;
                    l2_write_n  = 1'b0;
                    state_n     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, request and output registers; reset drops any outstanding L2 request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_store <= 1'b0;
            req_hit   <= 1'b0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            l2_addr   <= '0;
            l2_wdata  <= '0;
            l2_read   <= 1'b0;
            l2_write  <= 1'b0;
        end else begin
            state     <= state_n;
            req_addr  <= req_addr_n;
            req_wdata <= req_wdata_n;
            req_store <= req_store_n;
            req_hit   <= req_hit_n;
            cpu_rdata <= cpu_rdata_n;
            cpu_ready <= cpu_ready_n;
            cpu_hit   <= cpu_hit_n;
            l2_addr   <= l2_addr_n;
            l2_wdata  <= l2_wdata_n;
            l2_read   <= l2_read_n;
            l2_write  <= l2_write_n;
        end
    end

`ifdef L1_PERF_CNT_EN
    // Saturating hit/miss counters, one increment per lookup for loads and stores alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == ST_LOOKUP) begin
            if (lookup_hit) begin
                if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// tb/tb_l1_dcache.sv - directed self-checking bench for l1_dcache with a delay-programmable L2 model
module tb_l1_dcache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_hit;
    logic [31:0] l2_addr;
    logic [31:0] l2_wdata;
    logic        l2_read;
    logic        l2_write;
    logic [31:0] l2_rdata = '0;
    logic        l2_ready = 1'b0;
`ifdef L1_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    logic l2_en = 1'b1;
    int   l2_delay = 3;
    int   dcnt = 0;
    int   l2_rd_cnt = 0;
    int   l2_wr_cnt = 0;

    logic [31:0] t_rdata;
    logic        t_hit;
    int          t_lat;
    logic        t_saw_rd;
    logic        t_saw_wr;
    logic [31:0] t_l2_addr;
    logic [31:0] t_l2_wdata;

    l1_dcache dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_hit   (cpu_hit),
        .l2_addr   (l2_addr),
        .l2_wdata  (l2_wdata),
        .l2_read   (l2_read),
        .l2_write  (l2_write),
        .l2_rdata  (l2_rdata),
        .l2_ready  (l2_ready)
`ifdef L1_PERF_CNT_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] l2_model_data(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // L2 model: answers a held request after l2_delay negedges with a one-cycle l2_ready pulse.
    always @(negedge clk) begin
        if (l2_en) begin
            l2_ready = 1'b0;
            if (rst || !(l2_read || l2_write)) begin
                dcnt = 0;
            end else begin
                dcnt++;
                if (dcnt >= l2_delay) begin
                    l2_ready = 1'b1;
                    l2_rdata = l2_model_data(l2_addr);
                    if (l2_read) l2_rd_cnt++;
                    if (l2_write) l2_wr_cnt++;
                    dcnt = 0;
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic access(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        logic done;
        @(negedge clk);
        cpu_addr = a;
        cpu_wdata = d;
        cpu_write = wr;
        cpu_read = rd;
        t_lat = 1;
        t_saw_rd = 1'b0;
        t_saw_wr = 1'b0;
        t_l2_addr = '0;
        t_l2_wdata = '0;
        t_rdata = '0;
        t_hit = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            t_lat++;
            if (l2_read) begin
                t_saw_rd = 1'b1;
                t_l2_addr = l2_addr;
            end
            if (l2_write) begin
                t_saw_wr = 1'b1;
                t_l2_addr = l2_addr;
                t_l2_wdata = l2_wdata;
            end
            if (cpu_ready) begin
                done = 1'b1;
                t_rdata = cpu_rdata;
                t_hit = cpu_hit;
                cpu_read = 1'b0;
                cpu_write = 1'b0;
            end
        end
        total_cnt++;
        if (!done) begin
            $display("FAIL access_timeout addr=%h: cpu_ready not seen, required within 60 cycles", a);
            cpu_read = 1'b0;
            cpu_write = 1'b0;
        end else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge clk);
        total_cnt++; if (cpu_ready !== 1'b0) $display("FAIL reset_cpu_ready got=%b exp=0", cpu_ready); else pass_cnt++;
        total_cnt++; if (cpu_hit !== 1'b0) $display("FAIL reset_cpu_hit got=%b exp=0", cpu_hit); else pass_cnt++;
        total_cnt++; if (cpu_rdata !== 32'h0) $display("FAIL reset_cpu_rdata got=%h exp=0", cpu_rdata); else pass_cnt++;
        total_cnt++; if ({l2_read, l2_write} !== 2'b00) $display("FAIL reset_l2_req got=%b exp=00", {l2_read, l2_write}); else pass_cnt++;
        total_cnt++; if (l2_addr !== 32'h0) $display("FAIL reset_l2_addr got=%h exp=0", l2_addr); else pass_cnt++;
    endtask

    task automatic test_load_miss_hit();
        reset_dut();
        l2_delay = 3;
        access(1'b0, 1'b1, 32'h40, 32'h0);
        total_cnt++; if (t_saw_rd !== 1'b1) $display("FAIL miss_l2_read got=%b exp=1", t_saw_rd); else pass_cnt++;
        total_cnt++; if (t_l2_addr !== 32'h40) $display("FAIL miss_l2_addr got=%h exp=00000040", t_l2_addr); else pass_cnt++;
        total_cnt++; if (t_rdata !== 32'hDEADBEEF) $display("FAIL miss_rdata got=%h exp=deadbeef", t_rdata); else pass_cnt++;
        total_cnt++; if (t_hit !== 1'b0) $display("FAIL miss_hit got=%b exp=0", t_hit); else pass_cnt++;
        total_cnt++; if (t_lat != 6) $display("FAIL miss_latency got=%0d exp=6", t_lat); else pass_cnt++;
        access(1'b0, 1'b1, 32'h40, 32'h0);
        total_cnt++; if (t_hit !== 1'b1) $display("FAIL hit_hit got=%b exp=1", t_hit); else pass_cnt++;
        total_cnt++; if (t_rdata !== 32'hDEADBEEF) $display("FAIL hit_rdata got=%h exp=deadbeef", t_rdata); else pass_cnt++;
        total_cnt++; if (t_saw_rd !== 1'b0) $display("FAIL hit_no_l2_read got=%b exp=0", t_saw_rd); else pass_cnt++;
        total_cnt++; if (t_lat != 3) $display("FAIL hit_latency got=%0d exp=3", t_lat); else pass_cnt++;
    endtask

    task automatic test_conflict();
        int rd0;
        reset_dut();
        rd0 = l2_rd_cnt;
        access(1'b0, 1'b1, 32'h40, 32'h0);
        access(1'b0, 1'b1, 32'h80, 32'h0);
        total_cnt++; if (t_rdata !== 32'h0080FF7F) $display("FAIL conflict_rdata80 got=%h exp=0080ff7f", t_rdata); else pass_cnt++;
        total_cnt++; if (t_hit !== 1'b0) $display("FAIL conflict_hit80 got=%b exp=0", t_hit); else pass_cnt++;
        access(1'b0, 1'b1, 32'h40, 32'h0);
        total_cnt++; if (t_hit !== 1'b0) $display("FAIL conflict_hit40 got=%b exp=0", t_hit); else pass_cnt++;
        total_cnt++; if (t_rdata !== 32'hDEADBEEF) $display("FAIL conflict_rdata40 got=%h exp=deadbeef", t_rdata); else pass_cnt++;
        total_cnt++; if (l2_rd_cnt - rd0 != 3) $display("FAIL conflict_l2_reads got=%0d exp=3", l2_rd_cnt - rd0); else pass_cnt++;
    endtask

    task automatic test_store();
        access(1'b1, 1'b0, 32'h40, 32'h12345678);
        total_cnt++; if (t_saw_wr !== 1'b1) $display("FAIL st_hit_l2_write got=%b exp=1", t_saw_wr); else pass_cnt++;
        total_cnt++; if (t_l2_wdata !== 32'h12345678) $display("FAIL st_hit_l2_wdata got=%h exp=12345678", t_l2_wdata); else pass_cnt++;
        total_cnt++; if (t_l2_addr !== 32'h40) $display("FAIL st_hit_l2_addr got=%h exp=00000040", t_l2_addr); else pass_cnt++;
        total_cnt++; if (t_hit !== 1'b1) $display("FAIL st_hit_hit got=%b exp=1", t_hit); else pass_cnt++;
        access(1'b0, 1'b1, 32'h40, 32'h0);
        total_cnt++; if (t_hit !== 1'b1) $display("FAIL st_reload_hit got=%b exp=1", t_hit); else pass_cnt++;
        total_cnt++; if (t_rdata !== 32'h12345678) $display("FAIL st_reload_rdata got=%h exp=12345678", t_rdata); else pass_cnt++;
        access(1'b1, 1'b0, 32'h100, 32'hCAFEF00D);
        total_cnt++; if (t_hit !== 1'b0) $display("FAIL st_miss_hit got=%b exp=0", t_hit); else pass_cnt++;
        total_cnt++; if (t_saw_wr !== 1'b1) $display("FAIL st_miss_l2_write got=%b exp=1", t_saw_wr); else pass_cnt++;
        access(1'b0, 1'b1, 32'h100, 32'h0);
        total_cnt++; if (t_hit !== 1'b0) $display("FAIL st_noalloc_hit got=%b exp=0", t_hit); else pass_cnt++;
        total_cnt++; if (t_saw_rd !== 1'b1) $display("FAIL st_noalloc_l2_read got=%b exp=1", t_saw_rd); else pass_cnt++;
        total_cnt++; if (t_rdata !== 32'h0100FEFF) $display("FAIL st_noalloc_rdata got=%h exp=0100feff", t_rdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid_fill();
        logic any_ready;
        reset_dut();
        l2_en = 1'b0;
        l2_ready = 1'b0;
        @(negedge clk);
        cpu_addr = 32'h40;
        cpu_read = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (l2_read !== 1'b1) $display("FAIL fill_l2_read got=%b exp=1", l2_read); else pass_cnt++;
        any_ready = cpu_ready;
        rst = 1'b1;
        cpu_read = 1'b0;
        @(negedge clk);
        total_cnt++; if (l2_read !== 1'b0) $display("FAIL rst_fill_l2_read got=%b exp=0", l2_read); else pass_cnt++;
        any_ready = any_ready | cpu_ready;
        rst = 1'b0;
        l2_rdata = 32'h0BAD0BAD;
        l2_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            l2_ready = 1'b0;
            any_ready = any_ready | cpu_ready | l2_read | l2_write;
        end
        total_cnt++; if (any_ready !== 1'b0) $display("FAIL rst_fill_no_ready got=%b exp=0", any_ready); else pass_cnt++;
        l2_en = 1'b1;
        access(1'b0, 1'b1, 32'h40, 32'h0);
        total_cnt++; if (t_hit !== 1'b0) $display("FAIL rst_fill_reload_hit got=%b exp=0", t_hit); else pass_cnt++;
        total_cnt++; if (t_saw_rd !== 1'b1) $display("FAIL rst_fill_reload_l2_read got=%b exp=1", t_saw_rd); else pass_cnt++;
    endtask

    task automatic test_rw_priority();
        access(1'b1, 1'b1, 32'h44, 32'hA5A5A5A5);
        total_cnt++; if (t_saw_wr !== 1'b1) $display("FAIL prio_l2_write got=%b exp=1", t_saw_wr); else pass_cnt++;
        total_cnt++; if (t_saw_rd !== 1'b0) $display("FAIL prio_l2_read got=%b exp=0", t_saw_rd); else pass_cnt++;
        total_cnt++; if (t_l2_wdata !== 32'hA5A5A5A5) $display("FAIL prio_l2_wdata got=%h exp=a5a5a5a5", t_l2_wdata); else pass_cnt++;
        total_cnt++; if (t_l2_addr !== 32'h44) $display("FAIL prio_l2_addr got=%h exp=00000044", t_l2_addr); else pass_cnt++;
    endtask

`ifdef L1_PERF_CNT_EN
    task automatic test_perf_cnt();
        reset_dut();
        access(1'b0, 1'b1, 32'h40, 32'h0);
        access(1'b0, 1'b1, 32'h40, 32'h0);
        @(negedge clk);
        total_cnt++; if (hit_cnt !== 32'd1) $display("FAIL perf_hit_cnt got=%0d exp=1", hit_cnt); else pass_cnt++;
        total_cnt++; if (miss_cnt !== 32'd1) $display("FAIL perf_miss_cnt got=%0d exp=1", miss_cnt); else pass_cnt++;
        reset_dut();
        @(negedge clk);
        total_cnt++; if ({hit_cnt, miss_cnt} !== 64'd0) $display("FAIL perf_rst_cnt got=%h exp=0", {hit_cnt, miss_cnt}); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_load_miss_hit();
        test_conflict();
        test_store();
        test_reset_mid_fill();
        test_rw_priority();
`ifdef L1_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
